store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002 Parameter POS_W, default 4, reorder-buffer position width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  store entry offered by store reservation station this cycle.
REQ-006 in_position  input  POS_W  reorder-buffer position of offered store.
REQ-007 in_addr  input  32  computed effective address.
REQ-008 in_data  input  32  store data value.
REQ-009 full  output  1  buffer holds DEPTH entries; offers are ignored.
REQ-010 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 commit_valid  input  1  reorder buffer commits a store this cycle.
REQ-012 commit_position  input  POS_W  position being committed.
REQ-013 commit_miss  output  1  one-cycle pulse: commit matched no stored entry.
REQ-014 flush  input  1  misprediction; discard all uncommitted entries.
REQ-015 mem_req  output  1  memory write request.
REQ-016 mem_addr  output  32  write address, stable while mem_req high.
REQ-017 mem_data  output  32  write data, stable while mem_req high.
REQ-018 mem_ack  input  1  memory accepted the write this cycle.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries {valid, committed, position, addr, data} with head/tail pointers wrapping modulo DEPTH.
REQ-020 in_valid && !full SHALL write the entry at tail (committed=0) and advance tail; full is the registered value, so an offer when full is dropped even if a dequeue occurs the same cycle.
REQ-021 commit_valid SHALL set committed on the single stored valid entry whose position equals commit_position; the same-cycle incoming entry is not searched.
REQ-022 No match SHALL raise commit_miss for exactly the following cycle and change no state.
REQ-023 Drain FSM states IDLE and REQ: IDLE->REQ when head entry is valid and committed; mem_req=1 only in REQ, driving head addr/data.
REQ-024 In REQ, mem_ack SHALL dequeue head, advance head, and return to IDLE; without mem_ack, hold REQ with addr/data unchanged.
REQ-025 Minimum spacing: one IDLE cycle between consecutive requests; mem_req first asserts the cycle after the head entry becomes committed.
REQ-026 flush SHALL clear valid on all uncommitted entries and set tail to head plus number of committed entries (committed entries are contiguous from head).
REQ-027 flush with same-cycle in_valid SHALL drop the offer; flush with same-cycle commit applies the commit first, so that entry survives.
REQ-028 flush SHALL NOT abort an in-progress REQ (head is always committed).
REQ-029 count SHALL reflect enqueue, dequeue and flush of the previous edge; simultaneous enqueue and dequeue leaves count unchanged.
REQ-030 mem_ack while in IDLE SHALL be ignored.

Reset
REQ-031 reset SHALL asynchronously clear all valid/committed bits, head, tail, count, and force IDLE.
REQ-032 During and after reset: full=0, count=0, commit_miss=0, mem_req=0, mem_addr=0, mem_data=0.
REQ-033 Reset mid-REQ SHALL drop the request immediately; a later mem_ack is ignored.

Structure
REQ-034 POS_W default, DEPTH default and drain-state encoding SHALL live in the shared package with the opcode and reorder-buffer constants.
REQ-035 A sub-module wb_position_match (parallel position compare returning one-hot hit vector and any-hit) is natural; all else inline.

Verification
REQ-036 Enqueue pos 3 addr 0x100 data 0xAA; commit 3 next cycle -> mem_req two cycles later with 0x100/0xAA; ack -> count 0.
REQ-037 Fill 4 entries (pos 1-4); fifth offer -> full=1, dropped, count stays 4.
REQ-038 Entries pos 5,6,7; commit 5; flush -> count 1, only 0x.. of pos 5 written; next offer lands after it.
REQ-039 commit_position 9 with no entry -> commit_miss one cycle, count unchanged.
REQ-040 Hold mem_ack low 5 cycles in REQ -> mem_addr/mem_data stable; assert reset mid-REQ -> mem_req 0 immediately, count 0.
REQ-041 Enqueue/commit/drain 6 stores continuously -> pointers wrap, memory writes in program order.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared constants and types for the store write buffer and its neighbours.
package store_write_buffer_pkg;

    localparam int unsigned WB_DEPTH_DEF = 4;
    localparam int unsigned WB_POS_W_DEF = 4;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ROB_ENTRIES  = 1 << WB_POS_W_DEF;
    localparam int unsigned OPCODE_W     = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3
    } opcode_e;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

endpackage

// File: rtl/store_write_buffer_position_match.sv
// Parallel compare of a reorder-buffer position against every valid entry.
module wb_position_match
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEF,
    parameter int unsigned POS_W = WB_POS_W_DEF
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][POS_W-1:0] positions,
    input  logic [POS_W-1:0]            key,
    output logic [DEPTH-1:0]            hit_c,
    output logic                        any_hit_c
);

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            hit_c[i] = valid[i] && (positions[i] == key);
        end
        any_hit_c = |hit_c;
    end

endmodule

// File: rtl/store_write_buffer.sv
// Circular buffer holding speculative stores until the reorder buffer commits
// them, then draining committed entries to memory in program order.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEF,
    parameter int unsigned POS_W = WB_POS_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [POS_W-1:0]            in_position,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    input  logic                        commit_valid,
    input  logic [POS_W-1:0]            commit_position,
    output logic                        commit_miss,
    input  logic                        flush,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    input  logic                        mem_ack
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            committed_q, committed_d;
    logic [DEPTH-1:0][POS_W-1:0] pos_q;
    mem_wr_t                     payload_q [DEPTH];
    logic [PTR_W-1:0]            head_q, tail_q, head_d, tail_d;
    logic [CNT_W-1:0]            count_d, n_kept;
    drain_state_e                state_q, state_d;

    logic [DEPTH-1:0] hit;
    logic             any_hit;
    logic [DEPTH-1:0] commit_hit, committed_all, kept;
    logic             enq, deq, head_ready;

    wb_position_match #(.DEPTH(DEPTH), .POS_W(POS_W)) u_match (
        .valid     (valid_q),
        .positions (pos_q),
        .key       (commit_position),
        .hit_c     (hit),
        .any_hit_c (any_hit)
    );

    // Drain FSM next state.
    always_comb begin
        state_d    = state_q;
        head_ready = valid_q[head_q] && committed_q[head_q];
        case (state_q)
            DRAIN_IDLE: if (head_ready) state_d = DRAIN_REQ;
            DRAIN_REQ:  if (mem_ack)    state_d = DRAIN_IDLE;
            default:                    state_d = DRAIN_IDLE;
        endcase
    end

    // Buffer next state; a same-cycle commit is folded in before flush filtering.
    always_comb begin
        commit_hit    = commit_valid ? hit : '0;
        committed_all = committed_q | commit_hit;
        kept          = valid_q & committed_all;
        enq           = in_valid && !full && !flush;
        deq           = (state_q == DRAIN_REQ) && mem_ack;
        n_kept        = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_kept = n_kept + CNT_W'(kept[i]);
        end

        valid_d     = flush ? kept : valid_q;
        committed_d = committed_all & valid_d;
        if (deq) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
        end
        if (enq) begin
            valid_d[tail_q]     = 1'b1;
            committed_d[tail_q] = 1'b0;
        end

        head_d  = head_q + PTR_W'(deq);
        tail_d  = flush ? (head_q + PTR_W'(n_kept)) : (tail_q + PTR_W'(enq));
        count_d = flush ? (n_kept - CNT_W'(deq))
                        : (count + CNT_W'(enq) - CNT_W'(deq));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DRAIN_IDLE;
            valid_q     <= '0;
            committed_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count       <= '0;
            full        <= 1'b0;
            commit_miss <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count       <= count_d;
            full        <= (count_d == CNT_W'(DEPTH));
            commit_miss <= commit_valid && !any_hit;
            mem_req     <= (state_d == DRAIN_REQ);
            // Capture the head payload once on entry so it stays stable while waiting.
            if (state_q == DRAIN_IDLE && state_d == DRAIN_REQ) begin
                mem_addr <= payload_q[head_q].addr;
                mem_data <= payload_q[head_q].data;
            end
        end
    end

    // Entry payload storage needs no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (enq) begin
            pos_q[tail_q]     <= in_position;
            payload_q[tail_q] <= '{addr: in_addr, data: in_data};
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_position = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        full;
    logic [2:0]  count;
    logic        commit_valid = 1'b0;
    logic [3:0]  commit_position = '0;
    logic        commit_miss;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    store_write_buffer #(.DEPTH(4), .POS_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_position     (in_position),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .full            (full),
        .count           (count),
        .commit_valid    (commit_valid),
        .commit_position (commit_position),
        .commit_miss     (commit_miss),
        .flush           (flush),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_ack         (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid     = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
        mem_ack      = 1'b0;
    endtask

    task automatic offer(input logic [3:0] p, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_position = p; in_addr = a; in_data = d;
        tick(); clr();
    endtask

    task automatic commit(input logic [3:0] p);
        commit_valid = 1'b1; commit_position = p;
        tick(); clr();
    endtask

    initial begin
        int nxt, pend, k, acc;
        // Reset values
        repeat (2) tick();
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_miss", 64'(commit_miss), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'(mem_data), 64'd0);
        reset = 1'b0;
        tick();

        // Single store: enqueue, commit, drain
        offer(4'd3, 32'h100, 32'hAA);
        chk("s1_count", 64'(count), 64'd1);
        commit(4'd3);
        chk("s1_req_early", 64'(mem_req), 64'd0);
        chk("s1_miss", 64'(commit_miss), 64'd0);
        tick();
        chk("s1_req", 64'(mem_req), 64'd1);
        chk("s1_addr", 64'(mem_addr), 64'h100);
        chk("s1_data", 64'(mem_data), 64'hAA);
        mem_ack = 1'b1; tick(); clr();
        chk("s1_req_done", 64'(mem_req), 64'd0);
        chk("s1_count_done", 64'(count), 64'd0);

        // Fill to full; fifth offer dropped
        for (int i = 1; i <= 4; i++) offer(4'(i), 32'h400 + 32'(i), 32'(i));
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_full", 64'(full), 64'd1);
        offer(4'd5, 32'h500, 32'h5);
        chk("drop_count", 64'(count), 64'd4);
        chk("drop_full", 64'(full), 64'd1);
        commit(4'd5);
        chk("drop_miss", 64'(commit_miss), 64'd1);
        tick();
        chk("drop_miss_clr", 64'(commit_miss), 64'd0);
        flush = 1'b1; tick(); clr();
        chk("fl_all_count", 64'(count), 64'd0);
        chk("fl_all_full", 64'(full), 64'd0);
        chk("fl_all_req", 64'(mem_req), 64'd0);

        // Flush keeps only the committed entry; next offer lands behind it
        offer(4'd5, 32'h050, 32'h55);
        offer(4'd6, 32'h060, 32'h66);
        offer(4'd7, 32'h070, 32'h77);
        chk("fl_pre_count", 64'(count), 64'd3);
        commit(4'd5);
        flush = 1'b1; tick(); clr();
        chk("fl_count", 64'(count), 64'd1);
        chk("fl_req", 64'(mem_req), 64'd1);
        chk("fl_addr", 64'(mem_addr), 64'h050);
        offer(4'd8, 32'h080, 32'h88);
        chk("fl_next_count", 64'(count), 64'd2);
        mem_ack = 1'b1; tick(); clr();
        chk("fl_ack_count", 64'(count), 64'd1);
        chk("fl_ack_req", 64'(mem_req), 64'd0);
        commit(4'd8);
        tick();
        chk("fl_next_req", 64'(mem_req), 64'd1);
        chk("fl_next_addr", 64'(mem_addr), 64'h080);
        chk("fl_next_data", 64'(mem_data), 64'h88);
        mem_ack = 1'b1; tick(); clr();
        chk("fl_empty", 64'(count), 64'd0);

        // Commit with no matching entry
        commit(4'd9);
        chk("miss_pulse", 64'(commit_miss), 64'd1);
        chk("miss_count", 64'(count), 64'd0);
        tick();
        chk("miss_clr", 64'(commit_miss), 64'd0);

        // Held request stays stable; reset mid-request drops it
        offer(4'd10, 32'h1234, 32'hBEEF);
        commit(4'd10);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 64'(mem_req), 64'd1);
            chk("hold_addr", 64'(mem_addr), 64'h1234);
            chk("hold_data", 64'(mem_data), 64'hBEEF);
            tick();
        end
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; tick(); clr();
        chk("late_ack_req", 64'(mem_req), 64'd0);
        chk("late_ack_count", 64'(count), 64'd0);

        // Six stores streamed through; pointers wrap, program order preserved
        nxt = 0; pend = -1; k = 0;
        for (int cyc = 0; cyc < 80 && k < 6; cyc++) begin
            in_valid = (nxt < 6) && !full;
            in_position = 4'(nxt + 1);
            in_addr = 32'h200 + 32'(nxt * 4);
            in_data = 32'(nxt * 17 + 1);
            commit_valid = (pend >= 0);
            commit_position = 4'(pend + 1);
            mem_ack = mem_req;
            if (mem_req) begin
                chk("wrap_addr", 64'(mem_addr), 64'(32'h200 + 32'(k * 4)));
                chk("wrap_data", 64'(mem_data), 64'(k * 17 + 1));
                k++;
            end
            acc = in_valid ? nxt : -1;
            tick();
            if (in_valid) nxt++;
            pend = acc;
            clr();
        end
        chk("wrap_done", 64'(k), 64'd6);
        tick();
        chk("wrap_count", 64'(count), 64'd0);
        chk("wrap_full", 64'(full), 64'd0);
        chk("wrap_req", 64'(mem_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
